systolic_result_drain: RTL
==========================

Name: systolic_result_drain

Overview:
Output-side collector for the systolic PE array. It captures the column-skewed partial-sum stream from the array's bottom edge and deskews it, so all columns of one result vector line up. Aligned vectors are buffered in a FIFO and presented downstream on a valid/ready handshake. A start/done sequencer frames one matrix pass of a programmed number of vectors.

Parameters:
PE_ARRAY_W, 32, number of array columns (result vector length)
PE_ARRAY_H, 32, number of array rows (only sets the default of ARRAY_LAT)
OUT_DATA_WIDTH, 24, bits per column result
ARRAY_LAT, PE_ARRAY_H+1, cycles from i_start to column 0 result of vector 0 at the array bottom
FIFO_DEPTH, 16, aligned-vector FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_start  in  1  one-cycle pulse; begins a pass (same cycle the feeder issues vector 0)
i_num_vec  in  16  vectors in this pass (M), sampled on accepted i_start
i_col_data  in  OUT_DATA_WIDTH x [0:PE_ARRAY_W-1] unpacked  array bottom-edge outputs
o_vld  out  1  output vector valid
i_rdy  in  1  downstream ready
o_data  out  PE_ARRAY_W*OUT_DATA_WIDTH  aligned vector; column j at bits [j*OUT_DATA_WIDTH +: OUT_DATA_WIDTH]
o_busy  out  1  pass in progress (any state other than IDLE)
o_done  out  1  one-cycle pulse when pass fully drained
o_overflow  out  1  sticky: an aligned vector was dropped because the FIFO was full

Behaviour:
- Reset: all outputs 0. FIFO emptied, deskew registers cleared, state IDLE. Reset mid-pass aborts the pass with no o_done.
- Input timing contract: column j of vector m is valid on i_col_data[j] at cycle t0+ARRAY_LAT+m+j, where t0 is the i_start cycle.
- Deskew: column j passes through (PE_ARRAY_W-1-j) register stages; column W-1 is unregistered. All columns of vector m are then aligned at cycle tA(m) = t0+ARRAY_LAT+PE_ARRAY_W-1+m. The deskew chain runs every cycle and is never stalled.
- State machine:
  - IDLE: i_start accepted -> load M and the wait counter -> WAIT. If M==0 -> DONE instead.
  - WAIT: count ARRAY_LAT+PE_ARRAY_W-1 cycles -> CAPTURE.
  - CAPTURE: on each of M consecutive cycles (tA(0)..tA(M-1)), write the aligned vector to the FIFO. After the M-th write -> DRAIN.
  - DRAIN: when the FIFO is empty -> DONE.
  - DONE: o_done=1 for exactly one cycle -> IDLE.
- i_start while o_busy=1 is ignored, with no side effects.
- FIFO: write in CAPTURE only, read when o_vld&&i_rdy. Simultaneous read and write when full is allowed: the read frees the slot in the same cycle, no drop.
- Write when full with no same-cycle read: vector dropped, o_overflow set. The capture count still advances, so the pass still terminates.
- o_overflow clears only on rst or an accepted i_start.
- Output: o_vld = FIFO not empty. o_data is the FIFO head, registered read data, zero-bubble. Minimum latency from aligned capture to o_vld is 1 cycle.
- o_data stays stable while o_vld&&!i_rdy.
- Data is passed through untouched: no arithmetic, no saturation.
- The block must sustain 1 vector/cycle when i_rdy is held at 1.

Test Plan:
- W=4,H=4,ARRAY_LAT=5,DEPTH=8; start with M=3, i_col_data[j] = 100*m+j at t0+5+m+j, i_rdy=1 -> o_vld at cycles t0+9..t0+11 with o_data {3,2,1,0}, {103,102,101,100}, {203,202,201,200}; o_done one cycle after the FIFO empties; o_overflow=0.
- Same stimulus with M=8, i_rdy=0 throughout -> FIFO holds 8; o_overflow stays 0; raising i_rdy drains 8 vectors in order, back-to-back, then o_done.
- M=10, i_rdy=0 -> vectors 8 and 9 dropped, o_overflow=1 (sticky); after draining 8 vectors, o_done pulses; next i_start clears o_overflow.
- M=0 -> o_busy high for 1 cycle, o_done 1 cycle later, o_vld never asserts.
- Second i_start during CAPTURE with M=5 -> ignored; exactly 3 outputs and one o_done for the original M=3 pass.
- rst asserted mid-CAPTURE -> next cycle o_vld=0, o_busy=0, o_done never pulses; a fresh pass afterwards produces correct data with no stale deskew values.

Source files
------------

// File: rtl/systolic_result_drain_if.sv
// Downstream valid/ready stream carrying one aligned result vector per beat.
interface systolic_result_drain_if #(
    parameter int W  = 32,
    parameter int DW = 24
) ();
    logic            o_vld;
    logic            i_rdy;
    logic [W*DW-1:0] o_data;

    modport master (output o_vld, output o_data, input  i_rdy);
    modport slave  (input  o_vld, input  o_data, output i_rdy);
endinterface

// File: rtl/systolic_result_drain.sv
// Deskews the column-skewed systolic array output, buffers aligned vectors in a
// FIFO and frames one matrix pass of M vectors with a start/done sequencer.
module systolic_result_drain #(
    parameter int PE_ARRAY_W     = 32,
    parameter int PE_ARRAY_H     = 32,
    parameter int OUT_DATA_WIDTH = 24,
    parameter int ARRAY_LAT      = PE_ARRAY_H + 1,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [15:0]               i_num_vec,
    input  logic [OUT_DATA_WIDTH-1:0] i_col_data [0:PE_ARRAY_W-1],
    systolic_result_drain_if.master   out_if,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_overflow
);
    localparam int W        = PE_ARRAY_W;
    localparam int DW       = OUT_DATA_WIDTH;
    localparam int AW       = $clog2(FIFO_DEPTH);
    // Cycles spent in WAIT so that CAPTURE coincides with tA(0).
    localparam int WAIT_CYC = ARRAY_LAT + PE_ARRAY_W - 2;
    localparam int WCW      = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN, S_DONE} state_e;

    state_e          state_q, state_d;
    logic [WCW-1:0]  wait_q, wait_d;
    logic [15:0]     rem_q, rem_d;
    logic            ovf_q, ovf_d;
    logic [W*DW-1:0] aligned_vec;
    logic            fifo_wr, fifo_rd, fifo_push, fifo_full, fifo_vld;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic [W*DW-1:0] mem_q [FIFO_DEPTH];

    // Column j is delayed W-1-j cycles; the last column passes straight through.
    for (genvar j = 0; j < W; j++) begin : g_col
        localparam int D = W - 1 - j;
        if (D == 0) begin : g_thru
            assign aligned_vec[j*DW +: DW] = i_col_data[j];
        end else begin : g_dly
            logic [DW-1:0] dly_q [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) dly_q[k] <= '0;
                end else begin
                    // NOTE: sequential state uses <= so every stage samples the pre-edge value of its neighbour.
                    dly_q[0] <= i_col_data[j];
                    for (int k = 1; k < D; k++) dly_q[k] <= dly_q[k-1];
                end
            end
            assign aligned_vec[j*DW +: DW] = dly_q[D-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        wait_d  = wait_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        fifo_wr = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    ovf_d  = 1'b0;
                    rem_d  = i_num_vec;
                    wait_d = WCW'(WAIT_CYC - 1);
                    if (i_num_vec == 16'd0)  state_d = S_DONE;
                    else if (WAIT_CYC == 0)  state_d = S_CAPTURE;
                    else                     state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_CAPTURE;
                else              wait_d  = wait_q - WCW'(1);
            end
            S_CAPTURE: begin
                fifo_wr = 1'b1;
                rem_d   = rem_q - 16'd1;
                if (rem_q == 16'd1) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!fifo_vld) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A full FIFO only drops when the head is not leaving in the same cycle.
        if (fifo_wr && fifo_full && !fifo_rd) ovf_d = 1'b1;
    end

    assign fifo_vld  = (cnt_q != '0);
    assign fifo_full = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign fifo_rd   = fifo_vld && out_if.i_rdy;
    assign fifo_push = fifo_wr && (!fifo_full || fifo_rd);

    always_comb begin
        cnt_d = cnt_q;
        unique case ({fifo_push, fifo_rd})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (fifo_rd)   rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_d;
        end
    end

    // NOTE: storage is not reset; only the pointers are, and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (fifo_push) mem_q[wr_ptr_q] <= aligned_vec;
    end

    assign out_if.o_vld  = fifo_vld;
    assign out_if.o_data = fifo_vld ? mem_q[rd_ptr_q] : '0;
    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);
    assign o_overflow    = ovf_q;
endmodule
